// File: rtl/melody_sequencer.sv
// melody_sequencer: debounces the IR presence input and, on each new arrival,
// plays a fixed 8-note door chime through the tone generator, then locks out.
module melody_sequencer #(
  parameter int unsigned BEAT_CYCLES     = 12_500_000,
  parameter int unsigned GAP_CYCLES      = 500_000,
  parameter int unsigned COOLDOWN_CYCLES = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir0,
  input  logic        mute,
  output logic [17:0] tone_period,
  output logic        tone_en,
  output logic        busy,
  output logic [2:0]  note_idx
);
  localparam int unsigned M1 = (2 * BEAT_CYCLES > GAP_CYCLES) ? 2 * BEAT_CYCLES : GAP_CYCLES;
  localparam int unsigned M2 = (COOLDOWN_CYCLES > DEBOUNCE_CYCLES) ? COOLDOWN_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned MX = (M1 > M2) ? M1 : M2;
  localparam int W = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, NOTE, GAP, COOL} state_t;
  state_t       state_q, state_d;
  logic         s1_q, ir_s_q, ir_db_q, db_prev_q, trig_q, arm_q, db_hit;
  logic [1:0]   vld_q;
  logic [W-1:0] db_cnt_q, cnt_q, cnt_d;
  logic [2:0]   note_q, note_d;
  logic [17:0]  period_q, period_d;
  logic         en_q, en_d, busy_q, busy_d;

  function automatic logic [17:0] rom_period(input logic [2:0] i);
    case (i)
      3'd0:    return 18'd67568;
      3'd1:    return 18'd85131;
      3'd2:    return 18'd113636;
      3'd3:    return 18'd85131;
      3'd4:    return 18'd75843;
      3'd5:    return 18'd56818;
      3'd6:    return 18'd0;
      default: return 18'd85131;
    endcase
  endfunction

  function automatic logic [W-1:0] rom_dur(input logic [2:0] i);
    return (i == 3'd5 || i == 3'd7) ? W'(2 * BEAT_CYCLES - 1) : W'(BEAT_CYCLES - 1);
  endfunction

  assign db_hit = (ir_s_q != ir_db_q) && (db_cnt_q == W'(DEBOUNCE_CYCLES - 1));

  // arm_q blocks a trigger until ir has been seen low after reset, so a level
  // already high at reset release cannot start the melody.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      ir_s_q    <= 1'b0;
      ir_db_q   <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= '0;
      vld_q     <= '0;
      arm_q     <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      s1_q      <= ir0;
      ir_s_q    <= s1_q;
      db_cnt_q  <= (ir_s_q != ir_db_q && !db_hit) ? db_cnt_q + 1'b1 : '0;
      ir_db_q   <= db_hit ? ir_s_q : ir_db_q;
      db_prev_q <= ir_db_q;
      vld_q     <= {vld_q[0], 1'b1};
      arm_q     <= arm_q | (vld_q[1] & ~ir_s_q);
      trig_q    <= arm_q & ir_db_q & ~db_prev_q;
    end
  end

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    cnt_d   = cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (trig_q) begin
          state_d = NOTE;
          note_d  = '0;
          cnt_d   = rom_dur(3'd0);
        end
      end
      NOTE: if (cnt_q == '0) begin
        state_d = (note_q == 3'd7) ? COOL : GAP;
        note_d  = (note_q == 3'd7) ? 3'd0 : note_q;
        cnt_d   = (note_q == 3'd7) ? W'(COOLDOWN_CYCLES - 1) : W'(GAP_CYCLES - 1);
      end
      GAP: if (cnt_q == '0) begin
        state_d = NOTE;
        note_d  = note_q + 3'd1;
        cnt_d   = rom_dur(note_q + 3'd1);
      end
      COOL: if (cnt_q == '0) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    period_d = (state_d == NOTE) ? rom_period(note_d) : (state_d == GAP) ? period_q : '0;
    en_d     = (state_d == NOTE) && (period_d != '0) && !mute;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      note_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
    end
  end

  assign tone_period = period_q;
  assign tone_en     = en_q;
  assign busy        = busy_q;
  assign note_idx    = note_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed checks of play timing, debounce, lockout, mute and async reset.
module tb_melody_sequencer;
  logic        clk = 1'b0, rst = 1'b1, ir0 = 1'b0, mute = 1'b0;
  logic [17:0] tone_period;
  logic        tone_en, busy;
  logic [2:0]  note_idx;
  int          n_run = 0, n_fail = 0;
  int          per [8] = '{67568, 85131, 113636, 85131, 75843, 56818, 0, 85131};
  int          bts [8] = '{1, 1, 1, 1, 1, 2, 1, 2};

  melody_sequencer #(
    .BEAT_CYCLES(10), .GAP_CYCLES(2), .COOLDOWN_CYCLES(20), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .ir0(ir0), .mute(mute),
    .tone_period(tone_period), .tone_en(tone_en), .busy(busy), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] outs();
    return {busy, tone_en, note_idx, tone_period};
  endfunction

  task automatic idle_low(input int n);
    ir0 = 1'b0;
    repeat (n) tick();
  endtask

  // ir0 rises (held, or a pulse of `pulse` cycles), the melody is streamed
  // cycle by cycle against a table-built expectation; ir0 low windows, a mute
  // window and an async reset point can be injected.
  task automatic run_melody(input string tag, input int pulse, input int mon, input int moff,
                            input int w0, input int w1, input int w2, input int w3,
                            input int rst_at);
    logic [22:0] exp_q[$];
    logic [22:0] e;
    bit          lo;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < bts[i] * 10; c++)
        exp_q.push_back({1'b1, per[i] != 0, 3'(i), 18'(per[i])});
      if (i < 7) for (int c = 0; c < 2; c++)
        exp_q.push_back({1'b1, 1'b0, 3'(i), 18'(per[i])});
    end
    for (int c = 0; c < 20; c++) exp_q.push_back(23'd0 | (23'd1 << 22));
    ir0 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (pulse != 0 && k == pulse) ir0 = 1'b0;
    end
    chk({tag, "_lat_pre"}, {31'd0, tone_en}, 32'd0);
    tick();
    for (int t = 0; t < exp_q.size() + 12; t++) begin
      e = (t < exp_q.size()) ? exp_q[t] : 23'd0;
      if (mon >= 0 && t - 1 >= mon && t - 1 < moff) e[21] = 1'b0;
      chk(tag, {9'd0, outs()}, {9'd0, e});
      if (t == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk({tag, "_rst_period"}, {14'd0, tone_period}, 32'd0);
        chk({tag, "_rst_en"}, {31'd0, tone_en}, 32'd0);
        chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rst_idx"}, {29'd0, note_idx}, 32'd0);
        #1 rst = 1'b0;
        return;
      end
      lo = (t >= w0 && t < w1) || (t >= w2 && t < w3);
      ir0 = (pulse != 0) ? 1'b0 : !lo;
      mute = (mon >= 0 && t >= mon && t < moff);
      tick();
    end
    mute = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_outs", {9'd0, outs()}, 32'd0);
    rst = 1'b0;
    idle_low(8);
    chk("idle_outs", {9'd0, outs()}, 32'd0);
    run_melody("play", 0, -1, -1, -1, -1, -1, -1, -1);
    idle_low(8);
    ir0 = 1'b1;
    repeat (3) tick();
    ir0 = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("glitch", {30'd0, busy, tone_en}, 32'd0);
      tick();
    end
    run_melody("pulse5", 5, -1, -1, -1, -1, -1, -1, -1);
    idle_low(8);
    run_melody("lockout", 0, -1, -1, 2, 8, 104, 110, -1);
    idle_low(8);
    run_melody("fresh", 0, -1, -1, -1, -1, -1, -1, -1);
    idle_low(8);
    run_melody("mute", 0, 26, 39, -1, -1, -1, -1, -1);
    idle_low(8);
    run_melody("areset", 0, -1, -1, -1, -1, -1, -1, 65);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("no_retrig", {30'd0, busy, tone_en}, 32'd0);
    end
    idle_low(8);
    run_melody("after_rst", 0, -1, -1, -1, -1, -1, -1, -1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
